// File: rtl/hd44780_pkg.sv
// rtl/hd44780_pkg.sv - instruction masks, DDRAM line map, fill character and FSM states
// Shared by the HD44780 bus model and its DDRAM.
package hd44780_pkg;
  localparam logic [7:0] INSTR_CLEAR     = 8'h01;
  localparam logic [7:0] INSTR_HOME      = 8'h02;
  localparam logic [7:0] INSTR_ENTRY     = 8'h04;
  localparam logic [7:0] INSTR_DISPLAY   = 8'h08;
  localparam logic [7:0] INSTR_SHIFT     = 8'h10;
  localparam logic [7:0] INSTR_FUNCTION  = 8'h20;
  localparam logic [7:0] INSTR_SET_CGRAM = 8'h40;
  localparam logic [7:0] INSTR_SET_DDRAM = 8'h80;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE1_END  = 7'h27;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [6:0] LINE2_END  = 7'h67;
  localparam logic [6:0] LINE_LEN   = 7'd40;
  localparam int         DDRAM_SIZE = 80;
  localparam logic [7:0] FILL_CHAR  = 8'h20;

  typedef enum logic [1:0] {IDLE, EXEC, CLEAR_FILL, BUSY} lcd_state_t;

  function automatic logic dd_valid(input logic [6:0] a);
    return (a <= LINE1_END) || ((a >= LINE2_BASE) && (a <= LINE2_END));
  endfunction

  function automatic logic [6:0] dd_index(input logic [6:0] a);
    return (a >= LINE2_BASE) ? (a - LINE2_BASE + LINE_LEN) : a;
  endfunction

  // CGRAM addressing wraps in 6 bits; DDRAM jumps between the two line windows.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc, input logic cg);
    if (cg) return inc ? {1'b0, a[5:0] + 6'd1} : {1'b0, a[5:0] - 6'd1};
    if (inc) return (a == LINE1_END) ? LINE2_BASE : (a == LINE2_END) ? LINE1_BASE : a + 7'd1;
    return (a == LINE1_BASE) ? LINE2_END : (a == LINE2_BASE) ? LINE1_END : a - 7'd1;
  endfunction
endpackage

// File: rtl/hd44780_ddram.sv
// rtl/hd44780_ddram.sv - 80x8 display RAM, one write port, bus and debug read ports
// Addresses outside the two line windows ignore writes and read as 0x00.
module hd44780_ddram
  import hd44780_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic [6:0] bus_addr,
  output logic [7:0] bus_data,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);
  logic [7:0] mem [DDRAM_SIZE];

  always_ff @(posedge clk) begin
    if (we && dd_valid(waddr)) mem[dd_index(waddr)] <= wdata;
    dbg_data <= dd_valid(dbg_addr) ? mem[dd_index(dbg_addr)] : 8'h00;
  end

  assign bus_data = dd_valid(bus_addr) ? mem[dd_index(bus_addr)] : 8'h00;
endmodule

// File: rtl/hd44780_lcd_model.sv
// rtl/hd44780_lcd_model.sv - HD44780 character LCD controller bus model with busy timing
// Optional 64-byte CGRAM enabled by defining HD44780_CGRAM_EN.
module hd44780_lcd_model
  import hd44780_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES      = 1850,
  parameter int unsigned LONG_BUSY_CYCLES = 76500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic       busy_violation,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);
  lcd_state_t  state;
  logic [31:0] cnt;
  logic [6:0]  ac, fill_addr;
  logic        cg_sel, id, shift_en, disp_on, cursor_on, blink_on, dl, n_lines, font;
  logic        x_rs;
  logic [7:0]  x_data;

  logic [1:0]  e_sync, rs_sync, rw_sync;
  logic [7:0]  d_sync0, d_sync1;
  logic        e_d, armed, cap_rs, cap_rw;
  logic [7:0]  cap_data;
  logic        e_s, rs_s, rw_s, commit;
  logic [7:0]  dd_rd, cg_rd, rd_data;
  logic        dd_we;
  logic [6:0]  dd_waddr;
  logic [7:0]  dd_wdata;

  assign e_s    = e_sync[1];
  assign rs_s   = rs_sync[1];
  assign rw_s   = rw_sync[1];
  assign commit = armed & e_d & ~e_s;
  assign busy   = (state != IDLE);

  // Synchronizers free-run through reset so a pulse already high at release is never armed.
  always_ff @(posedge clk) begin
    e_sync  <= {e_sync[0], LCD_E};
    rs_sync <= {rs_sync[0], LCD_RS};
    rw_sync <= {rw_sync[0], LCD_RW};
    d_sync0 <= lcd_data_in;
    d_sync1 <= d_sync0;
    e_d     <= e_s;
    if (e_s) begin
      cap_rs   <= rs_s;
      cap_rw   <= rw_s;
      cap_data <= d_sync1;
    end
  end

  assign dd_we    = (state == CLEAR_FILL) | ((state == EXEC) & x_rs & ~cg_sel);
  assign dd_waddr = (state == CLEAR_FILL) ? fill_addr : ac;
  assign dd_wdata = (state == CLEAR_FILL) ? FILL_CHAR : x_data;
  assign rd_data  = cg_sel ? cg_rd : dd_rd;

  hd44780_ddram u_ddram (
    .clk      (clk),
    .we       (dd_we),
    .waddr    (dd_waddr),
    .wdata    (dd_wdata),
    .bus_addr (ac),
    .bus_data (dd_rd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

`ifdef HD44780_CGRAM_EN
  logic [7:0] cgram [64];
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) cgram[i] <= 8'h00;
    end else if ((state == EXEC) && x_rs && cg_sel) begin
      cgram[ac[5:0]] <= x_data;
    end
  end
  assign cg_rd = cgram[ac[5:0]];
`else
  assign cg_rd = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_FILL;  fill_addr <= LINE1_BASE;  cnt <= '0;
      ac <= '0;  cg_sel <= 1'b0;  id <= 1'b1;  shift_en <= 1'b0;
      disp_on <= 1'b0;  cursor_on <= 1'b0;  blink_on <= 1'b0;
      dl <= 1'b1;  n_lines <= 1'b0;  font <= 1'b0;
      x_rs <= 1'b0;  x_data <= 8'h00;  armed <= 1'b0;
      busy_violation <= 1'b0;  lcd_data_oe <= 1'b0;  lcd_data_out <= 8'h00;
    end else begin
      lcd_data_oe <= e_s & rw_s;
      if (e_s & rw_s) lcd_data_out <= rs_s ? rd_data : {busy, ac};
      if (e_s & ~e_d) armed <= 1'b1;
      else if (commit) armed <= 1'b0;

      case (state)
        IDLE: ;
        EXEC: begin
          state <= BUSY;
          cnt   <= BUSY_CYCLES - 1;
          if (x_rs) begin
            ac <= ac_step(ac, id, cg_sel);
          end else if (|(x_data & INSTR_SET_DDRAM)) begin
            ac <= x_data[6:0];  cg_sel <= 1'b0;
          end else if (|(x_data & INSTR_SET_CGRAM)) begin
            ac <= {1'b0, x_data[5:0]};  cg_sel <= 1'b1;
          end else if (|(x_data & INSTR_FUNCTION)) begin
            dl <= x_data[4];  n_lines <= x_data[3];  font <= x_data[2];
          end else if (|(x_data & INSTR_SHIFT)) begin
            if (!x_data[3]) ac <= ac_step(ac, x_data[2], cg_sel);
          end else if (|(x_data & INSTR_DISPLAY)) begin
            disp_on <= x_data[2];  cursor_on <= x_data[1];  blink_on <= x_data[0];
          end else if (|(x_data & INSTR_ENTRY)) begin
            id <= x_data[1];  shift_en <= x_data[0];
          end else if (|(x_data & INSTR_HOME)) begin
            ac <= '0;  cnt <= LONG_BUSY_CYCLES - 1;
          end else if (|(x_data & INSTR_CLEAR)) begin
            ac <= '0;  id <= 1'b1;  cg_sel <= 1'b0;
            fill_addr <= LINE1_BASE;  state <= CLEAR_FILL;
          end
        end
        CLEAR_FILL: begin
          if (fill_addr == LINE2_END) begin
            state <= BUSY;
            cnt   <= LONG_BUSY_CYCLES - 1;
          end
          fill_addr <= ac_step(fill_addr, 1'b1, 1'b0);
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1;
        end
        default: state <= IDLE;
      endcase

      // Reads never stall; a data read only advances AC when idle.
      if (commit) begin
        if (cap_rw) begin
          if (cap_rs && (state == IDLE)) ac <= ac_step(ac, id, cg_sel);
        end else if (state == IDLE) begin
          state  <= EXEC;
          x_rs   <= cap_rs;
          x_data <= cap_data;
        end else begin
          busy_violation <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hd44780_lcd_model.sv
// tb/tb_hd44780_lcd_model.sv - directed bench for the HD44780 model (CGRAM checks follow HD44780_CGRAM_EN)
module tb_hd44780_lcd_model;
  localparam int unsigned BUSY = 20;
  localparam int unsigned LONG = 60;

  logic       clk = 1'b0, reset = 1'b1;
  logic       LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [6:0] dbg_addr = 7'h00;
  logic [7:0] lcd_data_out, dbg_data;
  logic       lcd_data_oe, busy, busy_violation;
  logic       last_oe;
  int         checks = 0, failures = 0;

  hd44780_lcd_model #(.BUSY_CYCLES(BUSY), .LONG_BUSY_CYCLES(LONG)) dut (
    .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .busy(busy), .busy_violation(busy_violation), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, output logic [7:0] rd);
    LCD_RS = rs; LCD_RW = rw; lcd_data_in = d;
    repeat (2) @(posedge clk);
    #1 LCD_E = 1'b1;
    repeat (6) @(posedge clk);
    #1 rd = lcd_data_out;
    last_oe = lcd_data_oe;
    LCD_E = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic wr_instr(input logic [7:0] d);
    logic [7:0] unused;
    xfer(1'b0, 1'b0, d, unused);
  endtask

  task automatic wr_data(input logic [7:0] d);
    logic [7:0] unused;
    xfer(1'b1, 1'b0, d, unused);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic dbg_rd(input logic [6:0] a, output logic [7:0] v);
    dbg_addr = a;
    @(posedge clk); #1 v = dbg_data;
  endtask

  task automatic fill_check(input string tag);
    logic [7:0] v;
    int bad = 0;
    for (int a = 0; a <= 8'h67; a++) begin
      if (a <= 8'h27 || a >= 8'h40) begin
        dbg_rd(7'(a), v);
        if (v != 8'h20) bad++;
      end
    end
    check_eq(tag, bad, 0);
  endtask

  logic [7:0] sh_set [6] = '{8'hC0, 8'hE7, 8'h80, 8'hA7, 8'h95, 8'h95};
  logic [7:0] sh_ins [6] = '{8'h10, 8'h14, 8'h10, 8'h14, 8'h18, 8'h02};
  logic [7:0] sh_exp [6] = '{8'h27, 8'h00, 8'h67, 8'h40, 8'h15, 8'h00};

  initial begin
    logic [7:0] v;
    int n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 1);
    check_eq("rst_violation", {31'd0, busy_violation}, 0);
    check_eq("rst_oe", {31'd0, lcd_data_oe}, 0);
    check_eq("rst_data_out", {24'd0, lcd_data_out}, 8'h00);
    busy_len(n);
    check_eq("rst_busy_len", n, 80 + LONG);
    fill_check("rst_fill");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("rst_status", {24'd0, v}, 8'h00);
    check_eq("oe_on_read", {31'd0, last_oe}, 1);

    // Line-1 end write wraps AC into line 2
    wr_instr(8'hA7); wait_idle("idle_set27");
    wr_data(8'h41);
    check_eq("oe_on_write", {31'd0, last_oe}, 0);
    check_eq("busy_after_write", {31'd0, busy}, 1);
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("status_while_busy", {24'd0, v}, 8'hC0);
    wait_idle("idle_wr41");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("status_after_wrap", {24'd0, v}, 8'h40);
    dbg_rd(7'h27, v);
    check_eq("ddram_27", {24'd0, v}, 8'h41);

    wr_instr(8'hA7);
    xfer(1'b1, 1'b1, 8'h00, v);
    check_eq("read_while_busy", {24'd0, v}, 8'h41);
    wait_idle("idle_busy_read");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("ac_held_busy_read", {24'd0, v}, 8'h27);
    xfer(1'b1, 1'b1, 8'h00, v);
    check_eq("read_idle", {24'd0, v}, 8'h41);
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("ac_after_read", {24'd0, v}, 8'h40);

    wr_instr(8'h0C);
    busy_len(n);
    check_eq("short_busy_len", n, BUSY - 2);
    wr_instr(8'h02);
    busy_len(n);
    check_eq("home_busy_len", n, LONG - 2);

    // Decrement mode wraps line 2 start back to line 1 end
    wr_instr(8'h04); wait_idle("idle_entry_dec");
    wr_instr(8'hC0); wait_idle("idle_set40");
    wr_data(8'h42);  wait_idle("idle_wr42");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("status_dec_wrap", {24'd0, v}, 8'h27);
    dbg_rd(7'h40, v);
    check_eq("ddram_40", {24'd0, v}, 8'h42);

    wr_instr(8'h06); wait_idle("idle_entry_inc");
    wr_instr(8'h85); wait_idle("idle_set05");
    check_eq("no_violation_yet", {31'd0, busy_violation}, 0);
    wr_data(8'h33);
    wr_data(8'h55);
    check_eq("violation_set", {31'd0, busy_violation}, 1);
    wait_idle("idle_violation");
    dbg_rd(7'h05, v);
    check_eq("ddram_05", {24'd0, v}, 8'h33);
    dbg_rd(7'h06, v);
    check_eq("ddram_06_untouched", {24'd0, v}, 8'h20);
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("status_after_discard", {24'd0, v}, 8'h06);

    for (int i = 0; i < 6; i++) begin
      wr_instr(sh_set[i]); wait_idle("idle_shift_set");
      wr_instr(sh_ins[i]); wait_idle("idle_shift");
      xfer(1'b0, 1'b1, 8'h00, v);
      check_eq($sformatf("shift_%0d", i), {24'd0, v}, {24'd0, sh_exp[i]});
    end
    check_eq("violation_sticky", {31'd0, busy_violation}, 1);

    // Reset mid-clear with a write pulse straddling the reset
    wr_instr(8'h01);
    check_eq("busy_mid_fill", {31'd0, busy}, 1);
    LCD_RS = 1'b1; LCD_RW = 1'b0; lcd_data_in = 8'h77; LCD_E = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("reset2_violation", {31'd0, busy_violation}, 0);
    n = 0;
    while (busy && n < 2000) begin
      if (n == 5) LCD_E = 1'b0;
      n++; @(posedge clk); #1;
    end
    check_eq("reset2_busy_len", n, 80 + LONG);
    check_eq("half_pulse_discarded", {31'd0, busy_violation}, 0);
    fill_check("reset2_fill");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("reset2_status", {24'd0, v}, 8'h00);

`ifdef HD44780_CGRAM_EN
    wr_instr(8'h7F); wait_idle("idle_cg3f");
    wr_data(8'h1F);  wait_idle("idle_cg_wr1");
    wr_data(8'h1F);  wait_idle("idle_cg_wr2");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("cg_ac_wrap", {24'd0, v}, 8'h01);
    wr_instr(8'h7F); wait_idle("idle_cg3f_rd");
    xfer(1'b1, 1'b1, 8'h00, v);
    check_eq("cgram_3f", {24'd0, v}, 8'h1F);
    wr_instr(8'h40); wait_idle("idle_cg00_rd");
    xfer(1'b1, 1'b1, 8'h00, v);
    check_eq("cgram_00", {24'd0, v}, 8'h1F);
`else
    wr_instr(8'h7F); wait_idle("idle_cg3f");
    wr_data(8'h1F);
    check_eq("cg_write_busy", {31'd0, busy}, 1);
    wait_idle("idle_cg_wr");
    xfer(1'b0, 1'b1, 8'h00, v);
    check_eq("cg_ac_wrap", {24'd0, v}, 8'h00);
    xfer(1'b1, 1'b1, 8'h00, v);
    check_eq("cg_read_zero", {24'd0, v}, 8'h00);
    wr_instr(8'h80); wait_idle("idle_back_dd");
    xfer(1'b1, 1'b1, 8'h00, v);
    check_eq("dd_after_cg", {24'd0, v}, 8'h20);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
